// File: rtl/pmp_csr_regfile.sv
// PMP CSR register file: owns pmpcfg/pmpaddr state, runs IDLE->RD->WR->RSP read-modify-write per request.
// Optional PMP_NA4_SUPPRESS_EN: cfg bytes written with A=NA4 are stored as A=OFF (granularity G>=1).
module pmp_csr_regfile #(
  parameter int PMP_ENTRIES = 16,
  parameter int XLEN        = 64,
  parameter int PA_BITS     = 56
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  ReqValid,
  output logic                                  ReqReady,
  input  logic [1:0]                            ReqOp,
  input  logic [11:0]                           ReqCSR,
  input  logic [XLEN-1:0]                       ReqWData,
  output logic                                  RspValid,
  input  logic                                  RspReady,
  output logic [XLEN-1:0]                       RspRData,
  output logic                                  RspIllegal,
  output logic [PMP_ENTRIES-1:0][7:0]           PMPCFG_ARRAY_REGW,
  output logic [PMP_ENTRIES-1:0][PA_BITS-3:0]   PMPADDR_ARRAY_REGW
);

  localparam int NB = XLEN / 8;
  localparam int AW = PA_BITS - 2;
  localparam int CW = (AW < XLEN) ? AW : XLEN;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  state_t                            state_q;
  logic [1:0]                        op_q;
  logic [11:0]                       csr_q;
  logic [XLEN-1:0]                   wdata_q;
  logic                              ready_q;
  logic                              rsp_vld_q;
  logic                              ill_q;
  logic [XLEN-1:0]                   old_q;
  logic [PMP_ENTRIES-1:0][7:0]       cfg_q, cfg_d;
  logic [PMP_ENTRIES-1:0][AW-1:0]    addr_q, addr_d;

  logic                              cfg_ok;
  logic                              addr_sel;
  logic                              illegal;
  int                                cfg_base;
  int                                addr_idx;
  logic [XLEN-1:0]                   old_val;
  logic [XLEN-1:0]                   new_val;
  logic                              do_wr;
  logic [PMP_ENTRIES-1:0]            tor_lk;
  logic [7:0]                        nb;

  // pmpcfgN covers entries 4N..4N+NB-1; with XLEN=64 only even N exist.
  always_comb begin
    cfg_ok   = (csr_q[11:4] == 8'h3A) && !((XLEN == 64) && csr_q[0]);
    addr_sel = (csr_q >= 12'h3B0) && (csr_q <= 12'h3EF);
    illegal  = !(cfg_ok || addr_sel);
    cfg_base = 4 * int'(csr_q[3:0]);
    addr_idx = int'(csr_q) - 32'h3B0;
  end

  always_comb begin
    old_val = '0;
    if (cfg_ok) begin
      for (int b = 0; b < NB; b++)
        for (int e = 0; e < PMP_ENTRIES; e++)
          if (e == cfg_base + b) old_val[8*b +: 8] = cfg_q[e];
    end else if (addr_sel) begin
      for (int e = 0; e < PMP_ENTRIES; e++)
        if (e == addr_idx) old_val[CW-1:0] = addr_q[e][CW-1:0];
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   new_val = wdata_q;
      2'b01:   new_val = old_q | wdata_q;
      2'b10:   new_val = old_q & ~wdata_q;
      default: new_val = old_q;
    endcase
    do_wr = (op_q != 2'b11) && !ill_q;
  end

  // An entry's address is frozen when the next entry is a locked TOR region.
  always_comb begin
    tor_lk = '0;
    for (int e = 0; e < PMP_ENTRIES - 1; e++)
      tor_lk[e] = cfg_q[e+1][7] && (cfg_q[e+1][4:3] == 2'b01);
  end

  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    nb     = '0;
    if (do_wr && cfg_ok) begin
      for (int b = 0; b < NB; b++)
        for (int e = 0; e < PMP_ENTRIES; e++)
          if (e == cfg_base + b) begin
            nb      = new_val[8*b +: 8];
            nb[6:5] = 2'b00;
`ifdef PMP_NA4_SUPPRESS_EN
            if (nb[4:3] == 2'b10) nb[4:3] = 2'b00;
`else
            nb[4:3] = nb[4:3];
`endif
            if (!cfg_q[e][7] && !(!nb[0] && nb[1])) cfg_d[e] = nb;
          end
    end else if (do_wr && addr_sel) begin
      for (int e = 0; e < PMP_ENTRIES; e++)
        if ((e == addr_idx) && !cfg_q[e][7] && !tor_lk[e]) begin
          addr_d[e]         = '0;
          addr_d[e][CW-1:0] = new_val[CW-1:0];
        end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b11;
      csr_q     <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b1;
      rsp_vld_q <= 1'b0;
      ill_q     <= 1'b0;
      old_q     <= '0;
      cfg_q     <= '0;
      addr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (ReqValid && ready_q) begin
          op_q    <= ReqOp;
          csr_q   <= ReqCSR;
          wdata_q <= ReqWData;
          ready_q <= 1'b0;
          state_q <= S_RD;
        end
        S_RD: begin
          old_q   <= old_val;
          ill_q   <= illegal;
          state_q <= S_WR;
        end
        S_WR: begin
          cfg_q     <= cfg_d;
          addr_q    <= addr_d;
          rsp_vld_q <= 1'b1;
          state_q   <= S_RSP;
        end
        S_RSP: if (RspReady) begin
          rsp_vld_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign ReqReady           = ready_q;
  assign RspValid           = rsp_vld_q;
  assign RspRData           = old_q;
  assign RspIllegal         = ill_q;
  assign PMPCFG_ARRAY_REGW  = cfg_q;
  assign PMPADDR_ARRAY_REGW = addr_q;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Directed bench for pmp_csr_regfile (XLEN=64, 16 entries, PA_BITS=56).
module tb_pmp_csr_regfile;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ReqValid;
  logic              ReqReady;
  logic [1:0]        ReqOp;
  logic [11:0]       ReqCSR;
  logic [63:0]       ReqWData;
  logic              RspValid;
  logic              RspReady;
  logic [63:0]       RspRData;
  logic              RspIllegal;
  logic [15:0][7:0]  PMPCFG_ARRAY_REGW;
  logic [15:0][53:0] PMPADDR_ARRAY_REGW;

  int checks = 0;
  int errors = 0;

`ifdef PMP_NA4_SUPPRESS_EN
  localparam logic [63:0] NA4_EXP = 64'h0;
`else
  localparam logic [63:0] NA4_EXP = 64'h10;
`endif

  pmp_csr_regfile #(.PMP_ENTRIES(16), .XLEN(64), .PA_BITS(56)) dut (
    .clk(clk), .reset_n(reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqCSR(ReqCSR), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspReady(RspReady), .RspRData(RspRData), .RspIllegal(RspIllegal),
    .PMPCFG_ARRAY_REGW(PMPCFG_ARRAY_REGW), .PMPADDR_ARRAY_REGW(PMPADDR_ARRAY_REGW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] csr;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ready"}, 64'(ReqReady), 64'd1);
    chk({nm, "_rspvld"}, 64'(RspValid), 64'd0);
    chk({nm, "_rdata"}, RspRData, 64'd0);
    chk({nm, "_ill"}, 64'(RspIllegal), 64'd0);
    chk({nm, "_cfg"}, 64'(PMPCFG_ARRAY_REGW != '0), 64'd0);
    chk({nm, "_addr"}, 64'(PMPADDR_ARRAY_REGW != '0), 64'd0);
  endtask

  // Leaves the bench at the negedge of cycle T+1 (request accepted at the preceding posedge).
  task automatic issue(input logic [1:0] op, input logic [11:0] csr, input logic [63:0] wd);
    int w;
    w = 0;
    @(negedge clk);
    ReqValid = 1'b1; ReqOp = op; ReqCSR = csr; ReqWData = wd;
    while (!ReqReady && w < 50) begin @(negedge clk); w++; end
    if (!ReqReady) chk("req_ready_timeout", 64'(ReqReady), 64'd1);
    @(negedge clk);
    ReqValid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!RspValid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic consume;
    RspReady = 1'b1;
    @(negedge clk);
    RspReady = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] rd_seen;

    reset_n = 1'b0; ReqValid = 1'b0; ReqOp = 2'b11; ReqCSR = '0; ReqWData = '0; RspReady = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    vq.push_back('{2'd3, 12'h3A0, 64'h0,                  64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3B0, 64'h0,                  64'h0,                  1'b0});
    vq.push_back('{2'd0, 12'h3A0, 64'h8F7F,               64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3A0, 64'h0,                  64'h8F1F,               1'b0});
    vq.push_back('{2'd0, 12'h3A0, 64'h0,                  64'h8F1F,               1'b0});
    vq.push_back('{2'd3, 12'h3A0, 64'h0,                  64'h8F00,               1'b0});
    vq.push_back('{2'd0, 12'h3B0, 64'h1234,               64'h0,                  1'b0});
    vq.push_back('{2'd0, 12'h3B1, 64'h5678,               64'h0,                  1'b0});
    vq.push_back('{2'd0, 12'h3B2, 64'hABCD,               64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3B0, 64'h0,                  64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3B1, 64'h0,                  64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3B2, 64'h0,                  64'hABCD,               1'b0});
    vq.push_back('{2'd0, 12'h3A0, 64'h020000,             64'h8F00,               1'b0});
    vq.push_back('{2'd3, 12'h3A0, 64'h0,                  64'h8F00,               1'b0});
    vq.push_back('{2'd1, 12'h3A0, 64'h030000,             64'h8F00,               1'b0});
    vq.push_back('{2'd3, 12'h3A0, 64'h0,                  64'h038F00,             1'b0});
    vq.push_back('{2'd2, 12'h3A0, 64'h010000,             64'h038F00,             1'b0});
    vq.push_back('{2'd3, 12'h3A0, 64'h0,                  64'h038F00,             1'b0});
    vq.push_back('{2'd0, 12'h3A1, 64'hFFFF,               64'h0,                  1'b1});
    vq.push_back('{2'd3, 12'h3A0, 64'h0,                  64'h038F00,             1'b0});
    vq.push_back('{2'd0, 12'h3C5, 64'hFFFF,               64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3C5, 64'h0,                  64'h0,                  1'b0});
    vq.push_back('{2'd0, 12'h3F0, 64'h1,                  64'h0,                  1'b1});
    vq.push_back('{2'd0, 12'h3A2, 64'h10,                 64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3A2, 64'h0,                  NA4_EXP,                1'b0});
    vq.push_back('{2'd0, 12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b0});
    vq.push_back('{2'd3, 12'h3B3, 64'h0,                  64'h003F_FFFF_FFFF_FFFF, 1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      issue(vq[i].op, vq[i].csr, vq[i].wd);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd3);
      chk($sformatf("v%0d_rdata", i), RspRData, vq[i].exp_rd);
      chk($sformatf("v%0d_ill", i), 64'(RspIllegal), 64'(vq[i].exp_ill));
      consume();
    end

    chk("arr_cfg0", 64'(PMPCFG_ARRAY_REGW[0]), 64'h00);
    chk("arr_cfg1", 64'(PMPCFG_ARRAY_REGW[1]), 64'h8F);
    chk("arr_cfg2", 64'(PMPCFG_ARRAY_REGW[2]), 64'h03);
    chk("arr_cfg8", 64'(PMPCFG_ARRAY_REGW[8]), NA4_EXP);
    chk("arr_addr0", 64'(PMPADDR_ARRAY_REGW[0]), 64'h0);
    chk("arr_addr2", 64'(PMPADDR_ARRAY_REGW[2]), 64'hABCD);
    chk("arr_addr3", 64'(PMPADDR_ARRAY_REGW[3]), 64'h003F_FFFF_FFFF_FFFF);

    // Response backpressure: output held stable and no new request accepted.
    issue(2'd3, 12'h3B2, 64'h0);
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_vld", c), 64'(RspValid), 64'd1);
      chk($sformatf("bp%0d_rdata", c), RspRData, 64'hABCD);
      chk($sformatf("bp%0d_ready", c), 64'(ReqReady), 64'd0);
    end
    consume();
    chk("bp_done_ready", 64'(ReqReady), 64'd1);

    // Reset asserted during the WR cycle of a write.
    issue(2'd0, 12'h3A0, 64'h0F);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("postrst");
    ReqValid = 1'b1; ReqOp = 2'd3; ReqCSR = 12'h3A0; ReqWData = '0;
    chk("postrst_accept_rdy", 64'(ReqReady), 64'd1);
    @(negedge clk);
    ReqValid = 1'b0;
    chk("postrst_taken", 64'(ReqReady), 64'd0);
    wait_valid(lat);
    rd_seen = RspRData;
    chk("postrst_lat", 64'(lat), 64'd3);
    chk("postrst_rdata", rd_seen, 64'h0);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
